// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the reg_file_bp register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int RST_VAL   = 0;

  // Address width for a power-of-two register count (DEPTH >= 2).
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_file_bp_if.sv
// Write, reserve and dual read-port bundle of reg_file_bp.
interface reg_file_bp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rs_addr;
  logic [WIDTH-1:0] rs_data;
  logic             rs_busy;
  logic [AW-1:0]    rt_addr;
  logic [WIDTH-1:0] rt_data;
  logic             rt_busy;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [DEPTH-1:0] busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rs_addr, rt_addr, rsv_en, rsv_addr,
    input  rs_data, rs_busy, rt_data, rt_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs_addr, rt_addr, rsv_en, rsv_addr,
    output rs_data, rs_busy, rt_data, rt_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_bp_reg_cell.sv
// One WIDTH-bit storage register with load enable and async active-high reset.
module reg_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_q <= WIDTH'(RST_VAL);
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file_bp.sv
// DEPTH x WIDTH register file: 2 combinational reads, 1 write, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy to the read ports.
module reg_file_bp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic          clk,
  input  logic          rst_b,
  reg_file_bp_if.slave  bus
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] rs_d, rt_d;
  logic             rs_b, rt_b;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic wr_hit;
    assign wr_hit = bus.wr_en && (bus.wr_addr == AW'(i)) && !is_zero_reg(AW'(i));

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .rst  (rst_b),
      .en_i (wr_hit),
      .d_i  (bus.wr_data),
      .q_o  (regs[i])
    );
  end

  // Reserve is applied after the write clear so a fresh producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (bus.wr_en)  busy_d[bus.wr_addr]  = 1'b0;
    if (bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    if (ZERO_REG)   busy_d[0]            = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    rs_d = regs[bus.rs_addr];
    rs_b = busy_q[bus.rs_addr];
    rt_d = regs[bus.rt_addr];
    rt_b = busy_q[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == bus.rs_addr)) begin
      rs_d = bus.wr_data;
      rs_b = 1'b0;
    end
    if (bus.wr_en && (bus.wr_addr == bus.rt_addr)) begin
      rt_d = bus.wr_data;
      rt_b = 1'b0;
    end
`endif
    // Hard-wired zero overrides the bypass path as well.
    if (is_zero_reg(bus.rs_addr)) begin
      rs_d = '0;
      rs_b = 1'b0;
    end
    if (is_zero_reg(bus.rt_addr)) begin
      rt_d = '0;
      rt_b = 1'b0;
    end
  end

  assign bus.rs_data  = rs_d;
  assign bus.rs_busy  = rs_b;
  assign bus.rt_data  = rt_d;
  assign bus.rt_busy  = rt_b;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_bp.sv
// Scoreboard bench for reg_file_bp: one plain instance and one with ZERO_REG=1.
module tb_reg_file_bp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [15:0] rs_d;
    logic        rs_b;
    logic [15:0] rt_d;
    logic        rt_b;
    logic [7:0]  bv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  int   step = 0;

  exp_t        sb[$];
  logic [15:0] mdl_mem [2][8];
  logic [7:0]  mdl_bsy [2];

  always #5 clk = ~clk;

  reg_file_bp_if #(.WIDTH(16), .DEPTH(8)) bus0 ();
  reg_file_bp_if #(.WIDTH(16), .DEPTH(8)) bus1 ();

  reg_file_bp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) u_dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus0)
  );

  reg_file_bp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1)) u_dut_z (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mdl_mem[k][i] = '0;
      mdl_bsy[k] = '0;
    end
  endtask

  function automatic exp_t predict(input int k, input logic we, input logic [2:0] wa,
                                   input logic [15:0] wd, input logic [2:0] rsa,
                                   input logic [2:0] rta);
    exp_t e;
    e.rs_d = mdl_mem[k][rsa];
    e.rs_b = mdl_bsy[k][rsa];
    e.rt_d = mdl_mem[k][rta];
    e.rt_b = mdl_bsy[k][rta];
    if (BYP && we && wa == rsa) begin e.rs_d = wd; e.rs_b = 1'b0; end
    if (BYP && we && wa == rta) begin e.rt_d = wd; e.rt_b = 1'b0; end
    if (k == 1 && rsa == 3'd0) begin e.rs_d = '0; e.rs_b = 1'b0; end
    if (k == 1 && rta == 3'd0) begin e.rt_d = '0; e.rt_b = 1'b0; end
    e.bv = mdl_bsy[k];
    return e;
  endfunction

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra, input logic [2:0] rsa,
                       input logic [2:0] rta);
    bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd;
    bus0.rsv_en = re; bus0.rsv_addr = ra; bus0.rs_addr = rsa; bus0.rt_addr = rta;
    bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd;
    bus1.rsv_en = re; bus1.rsv_addr = ra; bus1.rs_addr = rsa; bus1.rt_addr = rta;
  endtask

  task automatic cycle(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra, input logic [2:0] rsa,
                       input logic [2:0] rta);
    exp_t e;
    drive(we, wa, wd, re, ra, rsa, rta);
    sb.push_back(predict(0, we, wa, wd, rsa, rta));
    sb.push_back(predict(1, we, wa, wd, rsa, rta));
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("s%0d rs_data", step), bus0.rs_data, e.rs_d);
    chk($sformatf("s%0d rs_busy", step), bus0.rs_busy, e.rs_b);
    chk($sformatf("s%0d rt_data", step), bus0.rt_data, e.rt_d);
    chk($sformatf("s%0d rt_busy", step), bus0.rt_busy, e.rt_b);
    chk($sformatf("s%0d busy_vec", step), bus0.busy_vec, e.bv);
    e = sb.pop_front();
    chk($sformatf("s%0d z rs_data", step), bus1.rs_data, e.rs_d);
    chk($sformatf("s%0d z rs_busy", step), bus1.rs_busy, e.rs_b);
    chk($sformatf("s%0d z rt_data", step), bus1.rt_data, e.rt_d);
    chk($sformatf("s%0d z rt_busy", step), bus1.rt_busy, e.rt_b);
    chk($sformatf("s%0d z busy_vec", step), bus1.busy_vec, e.bv);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (we && !(k == 1 && wa == 3'd0)) begin
        mdl_mem[k][wa] = wd;
        mdl_bsy[k][wa] = 1'b0;
      end
      if (re && !(k == 1 && ra == 3'd0)) mdl_bsy[k][ra] = 1'b1;
    end
    step++;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rs_data"}, bus0.rs_data, 32'h0);
    chk({tag, " rt_data"}, bus0.rt_data, 32'h0);
    chk({tag, " rs_busy"}, bus0.rs_busy, 32'h0);
    chk({tag, " busy_vec"}, bus0.busy_vec, 32'h0);
    chk({tag, " z rs_data"}, bus1.rs_data, 32'h0);
    chk({tag, " z busy_vec"}, bus1.busy_vec, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_clear();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd5);
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    // write/read on both ports
    cycle(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd5, 3'd5);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd5, 3'd5);
    // bypass of a pending write over an older stored value
    cycle(1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 3'd0, 3'd1);
    cycle(1'b1, 3'd2, 16'hA5A5, 1'b0, 3'd0, 3'd2, 3'd2);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd2, 3'd2);
    // scoreboard reserve then writeback
    cycle(1'b0, 3'd0, 16'h0,    1'b1, 3'd4, 3'd4, 3'd4);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd4, 3'd4);
    cycle(1'b1, 3'd4, 16'h1111, 1'b0, 3'd0, 3'd4, 3'd4);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd4, 3'd4);
    // write/reserve collision
    cycle(1'b1, 3'd6, 16'h00FF, 1'b1, 3'd6, 3'd6, 3'd7);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd6, 3'd6);
    // index 0 traffic (hard zero on the second instance)
    cycle(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd0, 3'd0);
    cycle(1'b1, 3'd0, 16'h1357, 1'b0, 3'd0, 3'd0, 3'd6);
    // independent write and reserve on different indices
    cycle(1'b1, 3'd1, 16'h2222, 1'b1, 3'd3, 3'd1, 3'd3);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd1, 3'd3);

    for (int n = 0; n < 60; n++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // async reset mid-cycle, no clock edge needed
    cycle(1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 3'd3, 3'd3);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd3, 3'd3);
    #1;
    rst_b = 1'b1;
    mdl_clear();
    #1;
    chk_reset_outputs("mid_reset");
    drive(1'b1, 3'd1, 16'h7777, 1'b0, 3'd0, 3'd1, 3'd1);
    #1;
    rst_b = 1'b0;
    cycle(1'b1, 3'd1, 16'h7777, 1'b0, 3'd0, 3'd1, 3'd1);
    cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd1, 3'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_bp.md
# reg_file_bp

Parametrised multi-port register file for the general-purpose processor, replacing the fixed 16-bit single-register cells in the datapath. It provides `DEPTH` registers of `WIDTH` bits, two combinational read ports, one synchronous write port and same-cycle write-to-read bypass. It also keeps a per-register busy scoreboard so that decode can stall on operands whose writeback is still pending.

## Interface
- `WIDTH`, 16, data width of each register.
- `DEPTH`, 8, number of registers; power of two, minimum 2.
- `ZERO_REG`, 0, when 1 register 0 reads as zero, ignores writes and is never busy.
- `clk` input 1, clock; all state updates on the rising edge.
- `rst_b` input 1, reset; asynchronous, active-high.
- `wr_en` input 1, write strobe.
- `wr_addr` input `AW`, write index; `AW` = clog2(`DEPTH`).
- `wr_data` input `WIDTH`, write data.
- `rs_addr` input `AW`, read port A index.
- `rs_data` output `WIDTH`, read port A data.
- `rs_busy` output 1, read port A register has a pending writeback.
- `rt_addr` input `AW`, read port B index.
- `rt_data` output `WIDTH`, read port B data.
- `rt_busy` output 1, read port B register has a pending writeback.
- `rsv_en` input 1, reserve strobe; marks a destination busy at issue.
- `rsv_addr` input `AW`, register to reserve.
- `busy_vec` output `DEPTH`, full scoreboard, bit i = register i busy.

## Operation
- Reset, asynchronous while `rst_b`=1:
  - every register clears to 0 and every busy bit clears to 0;
  - consequently `rs_data`, `rt_data`, `rs_busy`, `rt_busy` and `busy_vec` all read 0.
- Write: on a rising edge with `wr_en`=1, register[`wr_addr`] loads `wr_data` and busy[`wr_addr`] clears.
- Reserve: on a rising edge with `rsv_en`=1, busy[`rsv_addr`] sets.
- Simultaneous `wr_en` and `rsv_en` to the same index: the data is written and the busy bit ends at 1 (reserve wins; a new producer has been issued).
- Simultaneous operations on different indices are independent.
- Read: `rs_data`/`rt_data` are combinational from `rs_addr`/`rt_addr`.
- Busy outputs:
  - `rs_busy`/`rt_busy` reflect busy[addr] as registered.
  - A same-cycle write to that index clears the flag combinationally, matching the bypassed data.
  - A same-cycle reserve does not raise the flag until the next cycle.
- `ZERO_REG`=1:
  - writes and reserves to index 0 are dropped;
  - reads of index 0 return 0 and busy 0, bypass included.
- Both read ports may address the same register and then return identical data and busy flags.

## Timing
- Read latency 0 cycles (combinational).
- Write visible on non-bypassed reads 1 cycle after the strobe edge.
- Reserve visible on `busy_vec` and the busy outputs 1 cycle after the strobe edge.
- Reset takes effect immediately on assertion, independent of `clk`. After release, the first rising edge performs normal updates.
- Deasserting reset mid-cycle in which `wr_en`=1: the write takes place at the next rising edge; no partial update.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - when `wr_en`=1 and `wr_addr` equals a read address (non-zero if `ZERO_REG`), that port returns `wr_data` and busy 0 in the same cycle.
- Not defined:
  - read ports return the stored register value only;
  - a same-cycle write is visible from the next cycle;
  - the busy flag clears only after the write edge.

## Structure
- Package `regfile_pkg`:
  - default `WIDTH`/`DEPTH` constants;
  - address-width function clog2;
  - the reset value constant (0).
- Sub-module `reg_cell`: `WIDTH`-bit enable register with asynchronous active-high reset, instantiated `DEPTH` times.
- Read muxes, bypass comparators and the scoreboard live in the top level.

## Test plan
- Reset: write 0x1234 to reg 3, assert `rst_b` mid-cycle -> `rs_data`=0 and `busy_vec`=0 immediately, without a clock edge.
- Write/read: write 0xBEEF to reg 5 -> next cycle `rs_addr`=5 gives 0xBEEF; `rt_addr`=5 gives the same value.
- Bypass: stored reg 2 = 0x0001, write 0xA5A5 with `rs_addr`=2 in the same cycle -> with `REGFILE_BYPASS_EN`, `rs_data`=0xA5A5 that cycle; without it, 0x0001 that cycle and 0xA5A5 the next.
- Scoreboard: reserve reg 4 -> next cycle `busy_vec[4]`=1 and `rs_busy`=1. Write reg 4 -> busy clears after the edge, or that same cycle on the read port when bypass is enabled.
- Collision: `rsv_en` and `wr_en` both to reg 6, `wr_data`=0x00FF -> reg 6 = 0x00FF and `busy_vec[6]`=1.
- `ZERO_REG`=1: write 0xFFFF and reserve index 0 -> `rs_data`=0, `rs_busy`=0, `busy_vec[0]`=0 in all cycles.
